// File: rtl/sram_arbiter_pkg.sv
// Shared constants, owner encoding and counter helper for the SRAM arbiter slice.
// Imported by sram_arb_pick and sram_arbiter.
package sram_arbiter_pkg;

    localparam int MEM_ADDR_W     = 16;
    localparam int MEM_DATA_W     = 32;
    localparam int ARB_STARVE_LIM = 4;
    localparam int STARVE_W       = 4;

    // Who owns the SRAM read data that appears in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Counts data grants that fetch has had to sit through; saturates at lim.
    function automatic logic [STARVE_W-1:0] starve_next(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] lim,
        input logic                if_req,
        input logic                if_gnt,
        input logic                d_gnt
    );
        logic [STARVE_W-1:0] nxt;
        nxt = cnt;
        if (!if_req || if_gnt) begin
            nxt = '0;
        end else if (d_gnt && (cnt < lim)) begin
            nxt = cnt + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant pick: data wins by default, fetch wins once the
// starvation counter has reached its limit.
module sram_arb_pick
    import sram_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic starve_max,
    output logic if_gnt,
    output logic d_gnt
);

    logic w_if_forced;

    assign w_if_forced = if_req && starve_max;

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (d_req && !w_if_forced) begin
            d_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between fetch (read-only) and
// the data stage; tracks the owner of each in-flight response for routing.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_LIM = ARB_STARVE_LIM
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    input  logic                if_flush,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_ce,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic [1:0]          o_dbg_owner,
    output logic [STARVE_W-1:0] o_dbg_starve_cnt
);

    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

    logic [STARVE_W-1:0] r_starve_cnt;
    owner_e              r_owner;
    owner_e              w_owner_nxt;
    logic                w_starve_max;
    logic                w_if_gnt;
    logic                w_d_gnt;

    assign w_starve_max = (r_starve_cnt == LIM);

    sram_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_max (w_starve_max),
        .if_gnt     (w_if_gnt),
        .d_gnt      (w_d_gnt)
    );

    assign if_gnt = w_if_gnt;
    assign d_gnt  = w_d_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= starve_next(r_starve_cnt, LIM, if_req, w_if_gnt, w_d_gnt);
        end
    end

    // Owner state register: reloaded every cycle, so responses never bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_if_gnt) begin
            w_owner_nxt = OWN_IF;
        end else if (w_d_gnt) begin
            w_owner_nxt = OWN_D;
        end
    end

    // Flush only hides the stale fetch response; the SRAM read still happened.
    always_comb begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        case (r_owner)
            OWN_IF:  if_rvalid = !if_flush;
            OWN_D:   d_rvalid  = 1'b1;
            default: ;
        endcase
    end

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_comb begin
        mem_ce    = w_if_gnt | w_d_gnt;
        mem_we    = w_d_gnt & d_we;
        mem_addr  = if_addr;
        mem_wdata = '0;
        if (w_d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign o_dbg_owner      = r_owner;
    assign o_dbg_starve_cnt = r_starve_cnt;

`ifndef SYNTHESIS
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_if_gnt && w_d_gnt));
    a_if_gnt_req: assert property (@(posedge clk) disable iff (!rst_n)
        w_if_gnt |-> if_req);
    a_d_gnt_req: assert property (@(posedge clk) disable iff (!rst_n)
        w_d_gnt |-> d_req);
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_starve_cnt <= LIM);
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed test-plan scenarios, then randomized
// traffic checked against a reference model and a response scoreboard.
module tb_sram_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_gnt, if_flush, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    dbg_owner;
    logic [3:0]    dbg_starve;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_flush(if_flush),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .o_dbg_owner(dbg_owner), .o_dbg_starve_cnt(dbg_starve)
    );

    // Synchronous SRAM with registered read data.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                sram[mem_addr] <= mem_wdata;
                mem_rdata      <= mem_wdata;
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        logic          is_wr;
    } exp_t;

    exp_t          exp_if_q[$];
    exp_t          exp_d_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_starve = 0;
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive, check grants against the arbitration rules,
    // and record the responses that must appear one cycle later.
    task automatic drive_cycle(input logic ifr, input logic [AW-1:0] ifa,
                               input logic dr, input logic dwe, input logic [AW-1:0] da,
                               input logic [DW-1:0] dwd, input logic fl,
                               output logic g_if, output logic g_d);
        logic e_if, e_d;
        @(posedge clk);
        #1;
        if_req = ifr; if_addr = ifa; if_flush = fl;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        if (fl && exp_if_q.size() > 0 && exp_if_q[$].due == cyc)
            void'(exp_if_q.pop_back());
        #2;
        check("starve_cnt", 64'(dbg_starve), 64'(m_starve));
        e_if = ifr && (!dr || m_starve >= LIM);
        e_d  = dr && !e_if;
        check("if_gnt", 64'(if_gnt), 64'(e_if));
        check("d_gnt", 64'(d_gnt), 64'(e_d));
        check("mem_ce", 64'(mem_ce), 64'(e_if || e_d));
        check("mem_we", 64'(mem_we), 64'(e_d && dwe));
        if (e_if || e_d) check("mem_addr", 64'(mem_addr), 64'(e_d ? da : ifa));
        if (e_d && dwe) check("mem_wdata", 64'(mem_wdata), 64'(dwd));
        if (e_if) exp_if_q.push_back('{ref_mem[ifa], cyc + 1, 1'b0});
        if (e_d) begin
            if (dwe) begin
                ref_mem[da] = dwd;
                exp_d_q.push_back('{dwd, cyc + 1, 1'b1});
            end else begin
                exp_d_q.push_back('{ref_mem[da], cyc + 1, 1'b0});
            end
        end
        if (!ifr || e_if) m_starve = 0;
        else if (e_d && m_starve < LIM) m_starve++;
        g_if = e_if;
        g_d  = e_d;
    endtask

    // Monitor: every response cycle must match the scoreboard exactly.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (exp_if_q.size() > 0 && exp_if_q[0].due == cyc) begin
                e = exp_if_q.pop_front();
                check("if_rvalid", 64'(if_rvalid), 64'd1);
                if (if_rvalid) check("if_rdata", 64'(if_rdata), 64'(e.data));
            end else begin
                check("if_rvalid_idle", 64'(if_rvalid), 64'd0);
            end
            if (exp_d_q.size() > 0 && exp_d_q[0].due == cyc) begin
                e = exp_d_q.pop_front();
                check("d_rvalid", 64'(d_rvalid), 64'd1);
                if (d_rvalid && !e.is_wr) check("d_rdata", 64'(d_rdata), 64'(e.data));
            end else begin
                check("d_rvalid_idle", 64'(d_rvalid), 64'd0);
            end
        end
    end

    logic          g_if, g_d;
    logic          p_if, p_d, p_dwe, fl;
    logic [AW-1:0] p_ifa, p_da;
    logic [DW-1:0] p_dwd;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = DW'(i * 3 + 1);
            ref_mem[i] = DW'(i * 3 + 1);
        end
        sram[8'h10] = 16'h00A0; ref_mem[8'h10] = 16'h00A0;
        sram[8'h11] = 16'h00A1; ref_mem[8'h11] = 16'h00A1;
        sram[8'h12] = 16'h00A2; ref_mem[8'h12] = 16'h00A2;

        rst_n = 1'b0;
        if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_owner", 64'(dbg_owner), 64'd0);
        check("reset_starve", 64'(dbg_starve), 64'd0);
        check("reset_if_rvalid", 64'(if_rvalid), 64'd0);
        check("reset_d_rvalid", 64'(d_rvalid), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Fetch-only stream.
        drive_cycle(1, 8'h10, 0, 0, 0, 0, 0, g_if, g_d);
        drive_cycle(1, 8'h11, 0, 0, 0, 0, 0, g_if, g_d);
        drive_cycle(1, 8'h12, 0, 0, 0, 0, 0, g_if, g_d);

        // Data write then read of the same address.
        drive_cycle(0, 0, 1, 1, 8'h20, 16'h5A5A, 0, g_if, g_d);
        drive_cycle(0, 0, 1, 0, 8'h20, 0, 0, g_if, g_d);

        // Idle cycle, then sustained contention: D D D D IF repeating.
        drive_cycle(0, 0, 0, 0, 0, 0, 0, g_if, g_d);
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1, 8'h11, 1, 0, 8'h12, 0, 0, g_if, g_d);
            check("contend_pattern", 64'(g_d), 64'((k % 5) != 4));
        end

        // Flush of a stale fetch response; the new fetch is still granted.
        drive_cycle(1, 8'h10, 0, 0, 0, 0, 0, g_if, g_d);
        drive_cycle(1, 8'h12, 0, 0, 0, 0, 1, g_if, g_d);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, g_if, g_d);

        // Reset pulsed right after a data read grant drops its response.
        drive_cycle(1, 8'h05, 1, 0, 8'h30, 0, 0, g_if, g_d);
        @(posedge clk); #1;
        rst_n = 1'b0;
        if_req = 0; d_req = 0; if_flush = 0;
        exp_if_q.delete(); exp_d_q.delete(); m_starve = 0;
        #2;
        check("midrst_d_rvalid", 64'(d_rvalid), 64'd0);
        check("midrst_owner", 64'(dbg_owner), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        #1;
        check("postrst_owner", 64'(dbg_owner), 64'd0);
        check("postrst_starve", 64'(dbg_starve), 64'd0);

        // Randomized traffic with held requests and random flushes.
        p_if = 0; p_d = 0; p_ifa = '0; p_da = '0; p_dwe = 0; p_dwd = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!p_if && $urandom_range(0, 3) != 0) begin
                p_if = 1; p_ifa = AW'($urandom_range(0, 15));
            end
            if (!p_d && $urandom_range(0, 2) != 0) begin
                p_d = 1; p_dwe = 1'($urandom_range(0, 1));
                p_da = AW'($urandom_range(0, 15)); p_dwd = DW'($urandom);
            end
            fl = ($urandom_range(0, 4) == 0);
            drive_cycle(p_if, p_ifa, p_d, p_dwe, p_da, p_dwd, fl, g_if, g_d);
            if (g_if) p_if = 0;
            if (g_d)  p_d  = 0;
        end

        repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 0, g_if, g_d);
        @(posedge clk); #3;
        check("if_q_drained", 64'(exp_if_q.size()), 64'd0);
        check("d_q_drained", 64'(exp_d_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
